cn_seq_driver: RTL and testbench
================================

Name: cn_seq_driver

Overview:
- Sequential front end for the combinational CN block.
- Accepts one frame per operation over a handshaked nibble stream: six 4-bit operands plus a 5-bit opcode latched with the first nibble.
- Holds in_n0..in_n5 and opcode stable on the CN inputs and waits CN_LAT cycles for settling.
- Registers CN's 9-bit out_n and presents it with a valid pulse. This replaces free-running stimulus with a clocked producer/consumer of the CN interface.

Parameters:
- CN_LAT, 1, cycles between operands becoming stable at CN and capture of cn_out_n; legal range 1..15.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  nibble/opcode present this cycle.
- in_ready  out  1  block can accept a nibble this cycle.
- in_data  in  4  operand nibble; frame order is n0 first, n5 last.
- in_opcode  in  5  sampled only with the first nibble of a frame.
- cn_in_n0..cn_in_n5  out  4 each  operand registers driving CN.
- cn_opcode  out  5  opcode register driving CN.
- cn_out_n  in  9  CN result.
- out_valid  out  1  result available.
- out_n  out  9  registered CN result.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (async, rst_n low): state IDLE, nibble index 0, wait counter 0, all cn_in_n* = 0, cn_opcode = 0, out_n = 0, out_valid = 0. in_ready = 1 once reset is released.
- A transfer occurs on a rising edge with in_valid && in_ready. in_valid without in_ready is ignored; no data is lost on the source side.
- IDLE: in_ready = 1.
  - On a transfer: in_data goes to cn_in_n0, in_opcode goes to cn_opcode, index becomes 1, state goes to LOAD.
- LOAD: in_ready = 1.
  - Each transfer writes in_data to cn_in_n[index] and increments index.
  - The transfer with index == 5 writes cn_in_n5, clears index, loads the wait counter with CN_LAT, and moves to WAIT.
  - Gaps (in_valid low) are allowed at any point.
- WAIT: in_ready = 0.
  - The counter decrements each cycle.
  - When the counter reaches 1, the next edge captures cn_out_n into out_n and moves to OUT.
  - Operand registers are held constant throughout WAIT.
- OUT: out_valid = 1 for exactly one cycle (base build), then IDLE. in_ready = 0 in OUT.
- Minimum frame-to-result latency: the last-nibble edge plus CN_LAT edges puts out_valid high in cycle CN_LAT+1 after the last transfer. Back-to-back frames run every 6 + CN_LAT + 1 cycles.
- cn_in_n* and cn_opcode keep the last frame's values after OUT, until overwritten by the next frame.
- out_n keeps its value until the next capture.
- cn_out_n is sampled only at the capture edge; it is not registered otherwise.
- Widths are pass-through with no arithmetic on data. Index is 3 bits; values 6..7 are unreachable, and a default branch returns the FSM to IDLE.
- rst_n asserted mid-frame or mid-WAIT: the frame is abandoned and all state returns to reset values immediately. No partial result is ever presented.

Optional Feature:
- Macro: CN_BACKPRESSURE_EN.
- Defined:
  - Adds input port out_ready (1 bit).
  - OUT holds out_valid = 1 and out_n stable until out_ready is high on a clock edge, then goes to IDLE.
  - If out_ready is already high on entry, out_valid lasts one cycle.
- Undefined:
  - Port absent; out_valid is a single-cycle pulse regardless of downstream state.

Test Plan:
- Reset/defaults: hold rst_n = 0 for 3 cycles -> all outputs 0, in_ready = 1, busy = 0.
- Basic frame, CN_LAT = 1: stream 13,8,9,0,9,12 with opcode 5'b11001, CN stub returns 9'd123 -> cn_in_n0..5 = 13,8,9,0,9,12; cn_opcode = 11001; out_valid pulses 2 cycles after the last nibble with out_n = 123.
- Gapped input, CN_LAT = 3: stream 3,4,7,5,2,14 with opcode 5'b11011 and in_valid low for 2 cycles between nibbles 2 and 3 -> correct register mapping; in_ready = 0 for exactly 4 cycles; out_valid appears 4 cycles after the last nibble.
- Ignored input: assert in_valid during WAIT with in_data = 15 -> no register changes; next frame 8,15,3,14,13,5 with opcode 5'b10111 is accepted intact.
- Async reset mid-frame: assert rst_n low after 3 nibbles -> outputs 0 immediately, no out_valid. A fresh 6-nibble frame then completes normally.
- CN_BACKPRESSURE_EN defined: hold out_ready = 0 for 5 cycles after OUT entry -> out_valid stays 1, out_n is stable, in_ready = 0. Raising out_ready -> out_valid drops on the next edge and in_ready returns to 1.

Source files
------------

// File: rtl/cn_seq_driver.sv
// ---------------------------------------------------------------------------
// cn_seq_driver
//
// Sequential front end for the combinational CN block. A frame of six 4-bit
// operands arrives as a handshaked nibble stream (n0 first, n5 last). The
// opcode is sampled with the first nibble. Once the frame is complete the
// operand and opcode registers are held steady on the CN inputs for CN_LAT
// cycles. CN's result is then captured into out_n and presented with
// out_valid.
//
// Parameters:
//   CN_LAT     cycles from operands stable at CN to capture of cn_out_n (1..15)
//
// Optional feature (macro CN_BACKPRESSURE_EN):
//   defined    adds input out_ready; OUT holds out_valid/out_n until out_ready
//   undefined  out_valid is a single-cycle pulse
//
// Ports:
//   clk                 in   system clock, rising edge
//   rst_n               in   asynchronous active-low reset
//   in_valid            in   nibble/opcode present this cycle
//   in_ready            out  block can accept a nibble this cycle
//   in_data[3:0]        in   operand nibble
//   in_opcode[4:0]      in   opcode, sampled with the first nibble only
//   cn_in_n0..n5[3:0]   out  operand registers driving CN
//   cn_opcode[4:0]      out  opcode register driving CN
//   cn_out_n[8:0]       in   CN result
//   out_ready           in   downstream accepts result (CN_BACKPRESSURE_EN only)
//   out_valid           out  result available
//   out_n[8:0]          out  registered CN result
//   busy                out  high in any state other than IDLE
// ---------------------------------------------------------------------------
module cn_seq_driver #(
    parameter int unsigned CN_LAT = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [3:0] in_data,
    input  logic [4:0] in_opcode,
    output logic [3:0] cn_in_n0,
    output logic [3:0] cn_in_n1,
    output logic [3:0] cn_in_n2,
    output logic [3:0] cn_in_n3,
    output logic [3:0] cn_in_n4,
    output logic [3:0] cn_in_n5,
    output logic [4:0] cn_opcode,
    input  logic [8:0] cn_out_n,
`ifdef CN_BACKPRESSURE_EN
    input  logic       out_ready,
`endif
    output logic       out_valid,
    output logic [8:0] out_n,
    output logic       busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_WAIT,
        S_OUT
    } state_t;

    localparam logic [3:0] LAT_INIT = 4'(CN_LAT);

    state_t          state, state_nxt;
    logic [2:0]      idx, idx_nxt;
    logic [3:0]      cnt, cnt_nxt;
    logic [5:0]      wr_en;       // one-hot operand write enable
    logic            op_en;       // opcode write enable (first nibble)
    logic            capture;     // sample cn_out_n this edge
    logic [5:0][3:0] opnd;

    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            idx   <= '0;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // NOTE: every signal driven here gets a default first; a path that left
    // one unassigned would infer a latch.
    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        cnt_nxt   = cnt;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        wr_en     = '0;
        op_en     = 1'b0;
        capture   = 1'b0;

        case (state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    wr_en[0]  = 1'b1;
                    op_en     = 1'b1;
                    idx_nxt   = 3'd1;
                    state_nxt = S_LOAD;
                end
            end

            S_LOAD: begin
                in_ready = 1'b1;
                if (idx > 3'd5) begin
                    // Index 6..7 cannot occur; recover rather than write garbage.
                    idx_nxt   = '0;
                    state_nxt = S_IDLE;
                end else if (in_valid) begin
                    wr_en = 6'd1 << idx;
                    if (idx == 3'd5) begin
                        idx_nxt   = '0;
                        cnt_nxt   = LAT_INIT;
                        state_nxt = S_WAIT;
                    end else begin
                        idx_nxt = idx + 3'd1;
                    end
                end
            end

            S_WAIT: begin
                // Counter value 1 means this edge completes the settling time.
                if (cnt <= 4'd1) begin
                    capture   = 1'b1;
                    cnt_nxt   = '0;
                    state_nxt = S_OUT;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end

            S_OUT: begin
                out_valid = 1'b1;
`ifdef CN_BACKPRESSURE_EN
                if (out_ready) begin
                    state_nxt = S_IDLE;
                end
`else
                state_nxt = S_IDLE;
`endif
            end

            default: begin
                idx_nxt   = '0;
                cnt_nxt   = '0;
                state_nxt = S_IDLE;
            end
        endcase
    end

    // NOTE: the operand/result registers are plain flops (not a memory), so
    // they are reset; an abandoned frame must never leave stale CN inputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            opnd      <= '0;
            cn_opcode <= '0;
            out_n     <= '0;
        end else begin
            for (int i = 0; i < 6; i++) begin
                if (wr_en[i]) begin
                    opnd[i] <= in_data;
                end
            end
            if (op_en) begin
                cn_opcode <= in_opcode;
            end
            if (capture) begin
                out_n <= cn_out_n;
            end
        end
    end

    assign cn_in_n0 = opnd[0];
    assign cn_in_n1 = opnd[1];
    assign cn_in_n2 = opnd[2];
    assign cn_in_n3 = opnd[3];
    assign cn_in_n4 = opnd[4];
    assign cn_in_n5 = opnd[5];

    assign busy = (state != S_IDLE);

endmodule

// File: tb/tb_cn_seq_driver.sv
// ---------------------------------------------------------------------------
// tb_cn_seq_driver
//
// Two instances of cn_seq_driver (CN_LAT = 1 and CN_LAT = 3) share one input
// stream. The bench acts as source, CN stub and sink. A frame-level model
// records what each instance should hold: the operand/opcode values of the
// last accepted frame, and a result captured exactly CN_LAT edges after the
// last nibble. The CN stub changes its value every wait cycle, so a capture
// on the wrong edge is visible.
// Inputs are driven and outputs sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_cn_seq_driver;

    localparam int LAT_A = 1;
    localparam int LAT_B = 3;

    typedef logic [3:0] frame_t [6];

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic [3:0] in_data = '0;
    logic [4:0] in_opcode = '0;
    logic [8:0] cn_out_n = '0;
`ifdef CN_BACKPRESSURE_EN
    logic       out_ready = 1'b1;
`endif

    logic [1:0]            in_ready_w;
    logic [1:0]            out_valid_w;
    logic [1:0]            busy_w;
    logic [1:0][8:0]       out_n_w;
    logic [1:0][5:0][3:0]  cn_in_w;
    logic [1:0][4:0]       cn_op_w;

    // Model of what each instance must present.
    logic [3:0] m_opnd [2][6];
    logic [4:0] m_op   [2];
    logic [8:0] m_out  [2];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        cn_seq_driver #(.CN_LAT(g == 0 ? LAT_A : LAT_B)) u_dut (
            .clk      (clk),
            .rst_n    (rst_n),
            .in_valid (in_valid),
            .in_ready (in_ready_w[g]),
            .in_data  (in_data),
            .in_opcode(in_opcode),
            .cn_in_n0 (cn_in_w[g][0]),
            .cn_in_n1 (cn_in_w[g][1]),
            .cn_in_n2 (cn_in_w[g][2]),
            .cn_in_n3 (cn_in_w[g][3]),
            .cn_in_n4 (cn_in_w[g][4]),
            .cn_in_n5 (cn_in_w[g][5]),
            .cn_opcode(cn_op_w[g]),
            .cn_out_n (cn_out_n),
`ifdef CN_BACKPRESSURE_EN
            .out_ready(out_ready),
`endif
            .out_valid(out_valid_w[g]),
            .out_n    (out_n_w[g]),
            .busy     (busy_w[g])
        );
    end

    function automatic int lat_of(input int d);
        return (d == 0) ? LAT_A : LAT_B;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 6; i++) m_opnd[d][i] = '0;
            m_op[d]  = '0;
            m_out[d] = '0;
        end
    endtask

    // Register contents against the model.
    task automatic check_regs(input string tag);
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 6; i++)
                check($sformatf("%s d%0d cn_in_n%0d", tag, d, i), cn_in_w[d][i], m_opnd[d][i]);
            check($sformatf("%s d%0d cn_opcode", tag, d), cn_op_w[d], m_op[d]);
            check($sformatf("%s d%0d out_n", tag, d), out_n_w[d], m_out[d]);
        end
    endtask

    task automatic check_ctl(input string tag, input int d, input bit v, input bit r, input bit b);
        check($sformatf("%s d%0d out_valid", tag, d), out_valid_w[d], v);
        check($sformatf("%s d%0d in_ready", tag, d), in_ready_w[d], r);
        check($sformatf("%s d%0d busy", tag, d), busy_w[d], b);
    endtask

    // Send nibbles [0, count) of a frame; gap_before inserts two idle cycles
    // ahead of that nibble, rand_gaps inserts 0..1 random idle cycles.
    task automatic send_nibbles(input frame_t nib, input logic [4:0] op, input int count,
                                input int gap_before, input bit rand_gaps);
        for (int i = 0; i < count; i++) begin
            int gaps;
            gaps = (i == gap_before) ? 2 : 0;
            if (rand_gaps) gaps += int'($urandom_range(0, 1));
            for (int g = 0; g < gaps; g++) begin
                in_valid  = 1'b0;
                in_data   = 4'($urandom);
                in_opcode = 5'($urandom);
                @(negedge clk);
                for (int d = 0; d < 2; d++)
                    check($sformatf("gap n%0d d%0d in_ready", i, d), in_ready_w[d], 1'b1);
            end
            for (int d = 0; d < 2; d++)
                check($sformatf("pre n%0d d%0d in_ready", i, d), in_ready_w[d], 1'b1);
            in_valid  = 1'b1;
            in_data   = nib[i];
            in_opcode = (i == 0) ? op : 5'($urandom);
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                m_opnd[d][i] = nib[i];
                if (i == 0) m_op[d] = op;
                check($sformatf("post n%0d d%0d busy", i, d), busy_w[d], 1'b1);
            end
        end
        in_valid = 1'b0;
    endtask

    // Full frame plus the wait/result phase. fixed_res >= 0 makes the CN stub
    // return that constant; poke drives in_valid with 15 while both are busy;
    // hold keeps out_ready low for the result phase.
    task automatic run_frame(input string tag, input frame_t nib, input logic [4:0] op,
                             input int gap_before, input bit rand_gaps,
                             input int fixed_res, input bit poke, input bit hold);
        logic [8:0] v [LAT_B+1];
        int         last_k;
        send_nibbles(nib, op, 6, gap_before, rand_gaps);
        check_regs({tag, " loaded"});
        for (int d = 0; d < 2; d++) check_ctl({tag, " wait0"}, d, 1'b0, 1'b0, 1'b1);

        for (int k = 0; k <= LAT_B; k++)
            v[k] = (fixed_res >= 0) ? 9'(fixed_res) : 9'($urandom);
`ifdef CN_BACKPRESSURE_EN
        if (hold) out_ready = 1'b0;
`endif
        last_k = hold ? LAT_B + 5 : LAT_B + 1;
        for (int k = 1; k <= last_k; k++) begin
            cn_out_n = (k <= LAT_B) ? v[k] : 9'($urandom);
            if (poke && k <= LAT_A + 1) begin
                in_valid  = 1'b1;
                in_data   = 4'd15;
                in_opcode = 5'($urandom);
            end
            @(negedge clk);
            in_valid = 1'b0;
            for (int d = 0; d < 2; d++) begin
                int  l;
                bit  ev;
                l = lat_of(d);
                if (k == l) m_out[d] = v[l];
                ev = hold ? (k >= l) : (k == l);
                check_ctl($sformatf("%s k%0d", tag, k), d, ev,
                          !hold && (k > l), hold || (k <= l));
            end
            check_regs($sformatf("%s k%0d", tag, k));
        end
`ifdef CN_BACKPRESSURE_EN
        if (hold) begin
            out_ready = 1'b1;
            @(negedge clk);
            for (int d = 0; d < 2; d++) check_ctl({tag, " release"}, d, 1'b0, 1'b1, 1'b0);
            check_regs({tag, " release"});
        end
`endif
    endtask

    initial begin
        frame_t f;

        // Reset defaults.
        model_reset();
        repeat (3) @(negedge clk);
        check_regs("reset");
        for (int d = 0; d < 2; d++) check_ctl("reset", d, 1'b0, 1'b1, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);
        for (int d = 0; d < 2; d++) check_ctl("post_reset", d, 1'b0, 1'b1, 1'b0);

        // Basic frame, stub returns 123.
        f = '{4'd13, 4'd8, 4'd9, 4'd0, 4'd9, 4'd12};
        run_frame("basic", f, 5'b11001, -1, 1'b0, 123, 1'b0, 1'b0);

        // Two idle cycles between the third and fourth nibble.
        f = '{4'd3, 4'd4, 4'd7, 4'd5, 4'd2, 4'd14};
        run_frame("gapped", f, 5'b11011, 3, 1'b0, -1, 1'b0, 1'b0);

        // in_valid with data 15 while busy must be ignored.
        f = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6};
        run_frame("poke", f, 5'b00110, -1, 1'b0, -1, 1'b1, 1'b0);
        f = '{4'd8, 4'd15, 4'd3, 4'd14, 4'd13, 4'd5};
        run_frame("after_poke", f, 5'b10111, -1, 1'b0, -1, 1'b0, 1'b0);

        // Asynchronous reset after three nibbles.
        f = '{4'd10, 4'd11, 4'd12, 4'd1, 4'd2, 4'd3};
        send_nibbles(f, 5'b01010, 3, -1, 1'b0);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_regs("async_rst");
        for (int d = 0; d < 2; d++) check_ctl("async_rst", d, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) check_ctl($sformatf("post_rst c%0d", c), d, 1'b0, 1'b1, 1'b0);
        end
        check_regs("post_rst");
        f = '{4'd7, 4'd6, 4'd5, 4'd4, 4'd3, 4'd2};
        run_frame("fresh", f, 5'b10001, -1, 1'b0, -1, 1'b0, 1'b0);

`ifdef CN_BACKPRESSURE_EN
        f = '{4'd9, 4'd1, 4'd14, 4'd0, 4'd6, 4'd11};
        run_frame("hold", f, 5'b01101, -1, 1'b0, -1, 1'b0, 1'b1);
`endif

        // Random frames with random gaps.
        for (int t = 0; t < 20; t++) begin
            for (int i = 0; i < 6; i++) f[i] = 4'($urandom);
            run_frame($sformatf("rand%0d", t), f, 5'($urandom), -1, 1'b1, -1,
                      1'($urandom), 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
